uart_block_sender: RTL and testbench

//  Serialises a latched NBYTES-wide data block into a byte stream over the we/busy

---
 rtl/uart_block_sender.sv | 152 +++++++++++++++
 tb/tb_uart_block_sender.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_block_sender.sv
// uart_block_sender: latches an NBYTES*8-bit block and feeds it byte by byte to a uart over we/busy.
// Optional HEX_ASCII_EN: each byte goes out as two uppercase ASCII hex chars, then CR, LF.
module uart_block_sender #(
  parameter int NBYTES     = 16,
  parameter int MSB_FIRST  = 1,
  parameter int BUSY_LAT   = 2,
  parameter int GAP_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_start,
  input  logic [NBYTES*8-1:0]         i_data,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_uart_we,
  output logic [7:0]                  o_uart_byte,
  input  logic                        i_uart_busy,
  output logic [$clog2(NBYTES+1)-1:0] o_byte_idx,
  output logic [2:0]                  o_state
);

  localparam int DW = NBYTES * 8;
  localparam int IW = $clog2(NBYTES + 1);
`ifdef HEX_ASCII_EN
  localparam int NXFER = 2 * NBYTES + 2;
`else
  localparam int NXFER = NBYTES;
`endif
  localparam int XW   = (NXFER > 1) ? $clog2(NXFER) : 1;
  localparam int CMAX = (BUSY_LAT > GAP_CYCLES) ? BUSY_LAT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [XW-1:0] LAST_XFER = XW'(NXFER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_SETTLE, S_WAIT, S_GAP, S_DONE
  } state_t;

  state_t          state;
  logic [DW-1:0]   shadow;
  logic [XW-1:0]   xfer;
  logic [CW-1:0]   cnt;

  // Handshake: o_uart_we is a one-cycle strobe with o_uart_byte already valid; i_uart_busy
  // is ignored until BUSY_LAT cycles after the strobe, and the next strobe waits for it to be low.
  assign o_state = state;

  // Source byte for a transfer; CR/LF transfers clamp to the last byte.
  function automatic int src_idx(input logic [XW-1:0] x);
    int s;
`ifdef HEX_ASCII_EN
    s = int'(x) / 2;
`else
    s = int'(x);
`endif
    if (s > NBYTES - 1) s = NBYTES - 1;
    return s;
  endfunction

  function automatic logic [7:0] sel_byte(input logic [DW-1:0] blk, input int k);
    int s;
    s = (MSB_FIRST != 0) ? (NBYTES - 1 - k) : k;
    return blk[s*8 +: 8];
  endfunction

  function automatic logic [7:0] xfer_char(input logic [DW-1:0] blk, input logic [XW-1:0] x);
`ifdef HEX_ASCII_EN
    logic [7:0] b;
    logic [3:0] nib;
    logic [7:0] c;
    b   = sel_byte(blk, src_idx(x));
    nib = x[0] ? b[3:0] : b[7:4];
    c   = (nib < 4'd10) ? {4'h3, nib} : (8'h37 + {4'h0, nib});
    if (int'(x) == 2 * NBYTES) c = 8'h0D;
    else if (int'(x) == 2 * NBYTES + 1) c = 8'h0A;
    return c;
`else
    return sel_byte(blk, src_idx(x));
`endif
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      shadow      <= '0;
      xfer        <= '0;
      cnt         <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_uart_we   <= 1'b0;
      o_uart_byte <= '0;
      o_byte_idx  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            shadow      <= i_data;
            xfer        <= '0;
            o_byte_idx  <= '0;
            o_uart_we   <= 1'b1;
            o_uart_byte <= xfer_char(i_data, '0);
            o_busy      <= 1'b1;
            state       <= S_SEND;
          end
        end
        S_SEND: begin
          o_uart_we <= 1'b0;
          cnt       <= CW'(BUSY_LAT - 1);
          state     <= S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == '0) state <= S_WAIT;
          else cnt <= cnt - 1'b1;
        end
        S_WAIT: begin
          if (!i_uart_busy) begin
            if (xfer == LAST_XFER) begin
              o_done <= 1'b1;
              state  <= S_DONE;
            end else begin
              xfer       <= xfer + 1'b1;
              o_byte_idx <= IW'(src_idx(xfer + 1'b1));
              if (GAP_CYCLES > 0) begin
                cnt   <= CW'(GAP_CYCLES - 1);
                state <= S_GAP;
              end else begin
                o_uart_we   <= 1'b1;
                o_uart_byte <= xfer_char(shadow, xfer + 1'b1);
                state       <= S_SEND;
              end
            end
          end
        end
        S_GAP: begin
          if (cnt == '0) begin
            o_uart_we   <= 1'b1;
            o_uart_byte <= xfer_char(shadow, xfer);
            state       <= S_SEND;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          o_done <= 1'b0;
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_block_sender.sv
// Bench for uart_block_sender: three parameterisations checked every cycle against a
// transfer-level model (byte order, strobe timing from uart busy time, done, busy).
module tb_uart_block_sender;

`ifdef HEX_ASCII_EN
  localparam bit HEX_MODE = 1'b1;
  localparam int T1_N = 34;  localparam logic [7:0] T1_FIRST = 8'h33; localparam logic [7:0] T1_LAST = 8'h0A;
  localparam int T2_N = 10;  localparam logic [7:0] T2_B0 = 8'h44;    localparam logic [7:0] T2_B1 = 8'h34;
  localparam logic [7:0] T2_LAST = 8'h0A;
  localparam int T3_N = 10;  localparam logic [7:0] T3_FIRST = 8'h34; localparam logic [7:0] T3_LAST = 8'h0A;
  localparam logic [7:0] T4_FIRST = 8'h43;
  localparam int T6_N = 6;
  localparam logic [7:0] T6_EXP [6] = '{8'h33, 8'h41, 8'h30, 8'h46, 8'h0D, 8'h0A};
`else
  localparam bit HEX_MODE = 1'b0;
  localparam int T1_N = 16;  localparam logic [7:0] T1_FIRST = 8'h39; localparam logic [7:0] T1_LAST = 8'h32;
  localparam int T2_N = 4;   localparam logic [7:0] T2_B0 = 8'hD4;    localparam logic [7:0] T2_B1 = 8'hC3;
  localparam logic [7:0] T2_LAST = 8'hA1;
  localparam int T3_N = 4;   localparam logic [7:0] T3_FIRST = 8'h44; localparam logic [7:0] T3_LAST = 8'h11;
  localparam logic [7:0] T4_FIRST = 8'hC0;
  localparam int T6_N = 2;
  localparam logic [7:0] T6_EXP [6] = '{8'h3A, 8'h0F, 8'h00, 8'h00, 8'h00, 8'h00};
`endif

  localparam int NB_P  [3] = '{16, 4, 2};
  localparam int MSB_P [3] = '{1, 0, 1};
  localparam int BL_P  [3] = '{2, 3, 2};
  localparam int GP_P  [3] = '{0, 5, 0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]   start, busy_w, done_w, we_w, ubusy;
  logic [127:0] data [3];
  logic [7:0]   ubyte [3];
  logic [4:0]   idx_a;
  logic [2:0]   idx_b;
  logic [1:0]   idx_c;
  logic [4:0]   idx_w [3];
  logic [2:0]   st_a, st_b, st_c;
  int           ub [3];

  assign idx_w[0] = idx_a;
  assign idx_w[1] = {2'b00, idx_b};
  assign idx_w[2] = {3'b000, idx_c};

  uart_block_sender #(.NBYTES(16), .MSB_FIRST(1), .BUSY_LAT(2), .GAP_CYCLES(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start[0]), .i_data(data[0]), .o_busy(busy_w[0]),
    .o_done(done_w[0]), .o_uart_we(we_w[0]), .o_uart_byte(ubyte[0]), .i_uart_busy(ubusy[0]),
    .o_byte_idx(idx_a), .o_state(st_a));
  uart_block_sender #(.NBYTES(4), .MSB_FIRST(0), .BUSY_LAT(3), .GAP_CYCLES(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start[1]), .i_data(data[1][31:0]), .o_busy(busy_w[1]),
    .o_done(done_w[1]), .o_uart_we(we_w[1]), .o_uart_byte(ubyte[1]), .i_uart_busy(ubusy[1]),
    .o_byte_idx(idx_b), .o_state(st_b));
  uart_block_sender #(.NBYTES(2), .MSB_FIRST(1), .BUSY_LAT(2), .GAP_CYCLES(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .i_start(start[2]), .i_data(data[2][15:0]), .o_busy(busy_w[2]),
    .o_done(done_w[2]), .o_uart_we(we_w[2]), .o_uart_byte(ubyte[2]), .i_uart_busy(ubusy[2]),
    .o_byte_idx(idx_c), .o_state(st_c));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [7:0] model_char(input int nb, input int msbf, input logic [127:0] d, input int k);
    string      hexd;
    logic [7:0] b;
    int         src;
    hexd = "0123456789ABCDEF";
    src  = HEX_MODE ? k / 2 : k;
    if (src >= nb) src = nb - 1;
    b = 8'(d >> (8 * ((msbf != 0) ? (nb - 1 - src) : src)));
    if (!HEX_MODE) return b;
    if (k == 2 * nb) return 8'h0D;
    if (k == 2 * nb + 1) return 8'h0A;
    return (k % 2 == 0) ? hexd[b[7:4]] : hexd[b[3:0]];
  endfunction

  function automatic int model_idx(input int nb, input int k);
    int s;
    s = HEX_MODE ? k / 2 : k;
    if (s >= nb) s = nb - 1;
    return s;
  endfunction

  // uart: busy for ub[i] cycles after each write strobe
  int ucnt [3];
  always @(posedge clk) begin
    logic [2:0] w;
    w = we_w;
    #1;
    for (int i = 0; i < 3; i++) begin
      if (w[i]) ucnt[i] = ub[i];
      else if (ucnt[i] > 0) ucnt[i]--;
    end
    ubusy = {ucnt[2] > 0, ucnt[1] > 0, ucnt[0] > 0};
  end

  // scoreboard: expected queue of {idx, byte} per instance plus event timing
  for (genvar gi = 0; gi < 3; gi++) begin : g_sb
    localparam int NBY = NB_P[gi];
    localparam int NXF = HEX_MODE ? 2 * NBY + 2 : NBY;
    logic [15:0] exp_q [$];
    int cyc = 0;
    int next_we = -1;
    int done_at = -1;
    bit active = 1'b0;

    always @(posedge clk) begin
      if (!rst_n) begin
        active = 1'b0; next_we = -1; done_at = -1;
        exp_q.delete();
      end else if (!active && start[gi]) begin
        active = 1'b1; next_we = cyc + 1; done_at = -1;
        for (int k = 0; k < NXF; k++)
          exp_q.push_back({8'(model_idx(NBY, k)), model_char(NBY, MSB_P[gi], data[gi], k)});
      end else if (active && done_at == cyc) begin
        active = 1'b0; done_at = -1;
      end
      cyc++;
    end

    always @(negedge clk) begin
      logic [15:0] e;
      int c1, c2;
      if (!rst_n) begin
        check($sformatf("dut%0d.rst_we", gi), we_w[gi], 0);
        check($sformatf("dut%0d.rst_busy", gi), busy_w[gi], 0);
        check($sformatf("dut%0d.rst_done", gi), done_w[gi], 0);
      end else begin
        check($sformatf("dut%0d.we@%0d", gi, cyc), we_w[gi], active && cyc == next_we);
        check($sformatf("dut%0d.busy@%0d", gi, cyc), busy_w[gi], active);
        check($sformatf("dut%0d.done@%0d", gi, cyc), done_w[gi], active && cyc == done_at);
        if (active && cyc == next_we && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("dut%0d.byte@%0d", gi, cyc), ubyte[gi], e[7:0]);
          check($sformatf("dut%0d.idx@%0d", gi, cyc), idx_w[gi], e[15:8]);
          c1 = cyc + 1 + BL_P[gi];
          c2 = cyc + ub[gi] + 1;
          if (c2 > c1) c1 = c2;
          if (exp_q.size() > 0) next_we = c1 + 1 + GP_P[gi];
          else begin next_we = -1; done_at = c1 + 1; end
        end
      end
    end
  end

  // ---------------- capture for literal checks ----------------
  logic [7:0] cap_q0 [$], cap_q1 [$], cap_q2 [$];
  int wc_q1 [$];
  int done_n [3];
  int tcyc = 0;
  int t_acc;

  always @(negedge clk) begin
    tcyc++;
    if (we_w[0]) cap_q0.push_back(ubyte[0]);
    if (we_w[1]) begin cap_q1.push_back(ubyte[1]); wc_q1.push_back(tcyc); end
    if (we_w[2]) cap_q2.push_back(ubyte[2]);
    for (int i = 0; i < 3; i++) if (done_w[i]) done_n[i]++;
  end

  // ---------------- driver tasks ----------------
  task automatic start_block(input int i, input logic [127:0] d);
    @(posedge clk); #1;
    data[i] = d; start[i] = 1'b1;
    @(negedge clk); #1;
    t_acc = tcyc;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, input string name);
    int n;
    n = 0;
    while (!done_w[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, ".done_seen"}, done_w[i], 1);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int d0, cnt, n;
    rst_n = 1'b1; start = '0; ub[0] = 10; ub[1] = 0; ub[2] = 3;
    for (int i = 0; i < 3; i++) data[i] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.byte", ubyte[0], 8'h00);
    check("reset.idx", idx_a, 0);
    check("reset.state", st_a, 0);
    #1 rst_n = 1'b1;

    // model pinned to hand-computed characters
    check("model.t1_first", model_char(16, 1, 128'h3925841d02dc09fbdc118597196a0b32, 0), T1_FIRST);
    check("model.t2_first", model_char(4, 0, 128'hA1B2C3D4, 0), T2_B0);
    check("model.t6_second", model_char(2, 1, 128'h3A0F, 1), T6_EXP[1]);

    // 1: default params, uart busy 10 cycles
    cap_q0.delete(); d0 = done_n[0];
    start_block(0, 128'h3925841d02dc09fbdc118597196a0b32);
    wait_done(0, 1000, "t1");
    repeat (5) @(negedge clk);
    check("t1.count", cap_q0.size(), T1_N);
    if (cap_q0.size() == T1_N) begin
      check("t1.first", cap_q0[0], T1_FIRST);
      check("t1.second", cap_q0[1], HEX_MODE ? 8'h39 : 8'h25);
      check("t1.last", cap_q0[T1_N-1], T1_LAST);
    end
    check("t1.done_pulses", done_n[0] - d0, 1);

    // 2 + 5: LSB first, BUSY_LAT=3, GAP=5, zero-latency uart
    @(posedge clk); #1; cap_q1.delete(); wc_q1.delete();
    start_block(1, 128'hA1B2C3D4);
    wait_done(1, 300, "t2");
    check("t2.count", cap_q1.size(), T2_N);
    if (cap_q1.size() == T2_N) begin
      check("t2.b0", cap_q1[0], T2_B0);
      check("t2.b1", cap_q1[1], T2_B1);
      check("t2.last", cap_q1[T2_N-1], T2_LAST);
      check("t2.first_latency", wc_q1[0] - t_acc, 1);
      for (int k = 1; k < T2_N; k++) check("t5.spacing", wc_q1[k] - wc_q1[k-1], 10);
    end

    // 3: start held high, data changed mid-block
    @(posedge clk); #1; cap_q1.delete(); d0 = done_n[1];
    data[1] = 128'h11223344; start[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 data[1] = 128'h55667788;
    wait_done(1, 300, "t3");
    @(posedge clk); #1 start[1] = 1'b0;
    repeat (40) @(negedge clk);
    check("t3.count", cap_q1.size(), T3_N);
    if (cap_q1.size() == T3_N) begin
      check("t3.first", cap_q1[0], T3_FIRST);
      check("t3.last", cap_q1[T3_N-1], T3_LAST);
    end
    check("t3.done_pulses", done_n[1] - d0, 1);

    // 4: reset after 3rd strobe
    @(posedge clk); #1; d0 = done_n[0];
    start_block(0, 128'h0123456789abcdef0123456789abcdef);
    cnt = (we_w[0] === 1'b1) ? 1 : 0;
    n = 0;
    while (cnt < 3 && n < 200) begin
      @(negedge clk); n++;
      if (we_w[0]) cnt++;
    end
    check("t4.third_we", we_w[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4.we_async", we_w[0], 0);
    check("t4.busy_async", busy_w[0], 0);
    repeat (12) @(negedge clk);
    #1 rst_n = 1'b1;
    check("t4.no_done", done_n[0] - d0, 0);
    @(posedge clk); #1; cap_q0.delete();
    start_block(0, 128'hC0C1C2C3C4C5C6C7C8C9CACBCCCDCECF);
    wait_done(0, 1000, "t4");
    check("t4.restart_count", cap_q0.size(), T1_N);
    if (cap_q0.size() > 0) check("t4.restart_first", cap_q0[0], T4_FIRST);

    // 6: NBYTES=2, uart busy 3 cycles
    @(posedge clk); #1; cap_q2.delete();
    start_block(2, 128'h3A0F);
    wait_done(2, 300, "t6");
    check("t6.count", cap_q2.size(), T6_N);
    if (cap_q2.size() == T6_N)
      for (int k = 0; k < T6_N; k++) check($sformatf("t6.char%0d", k), cap_q2[k], T6_EXP[k]);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
